program_sequencer: RTL and testbench

Fetch/issue controller for the execution unit: on a `run` request it steps a program counter through the synchronous program ROM and presents each 8-bit opcode/operand pair to the execution unit's `opcode`/`operand` inputs. It inserts skip bubbles for the skip-next opcodes and stops on HALT or at the end of ROM. On finishing it pulses `start` so the execution unit captures its O register into `cpuOut`.

---
 rtl/program_sequencer.sv | 85 ++++++++
 tb/tb_program_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: ROM fetch/issue controller with skip-next bubbles, HALT and end-of-ROM stop.
// Optional sequencer jumps on opcode F0 when SEQ_JUMP_EN is defined.
module program_sequencer #(
    parameter int ROM_ADDRESS_WIDTH = 5,
    parameter int OP_WIDTH = 8,
    parameter logic [OP_WIDTH-1:0] SNZA_OP = 8'h0A,
    parameter logic [OP_WIDTH-1:0] SNZS_OP = 8'h0B
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         skip_cond,
    output logic                         rom_en,
    output logic [ROM_ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [2*OP_WIDTH-1:0]        rom_data,
    output logic [OP_WIDTH-1:0]          opcode,
    output logic [OP_WIDTH-1:0]          operand,
    output logic                         issue,
    output logic                         busy,
    output logic                         start,
    output logic [ROM_ADDRESS_WIDTH-1:0] pc
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
    localparam logic [OP_WIDTH-1:0] HALT_OP = '1;
    state_t state;
    logic [OP_WIDTH-1:0] op_r, opd_r, f_op, f_opd, e_op, e_opd;
    logic skip_pend, skipped, halt, jump, nop, last, skip_op;
    assign f_op = rom_data[2*OP_WIDTH-1:OP_WIDTH];
    assign f_opd = rom_data[OP_WIDTH-1:0];
    assign skipped = skip_pend && skip_cond;
    assign halt = !skipped && f_op == HALT_OP;
`ifdef SEQ_JUMP_EN
    localparam logic [OP_WIDTH-1:0] JMP_OP = OP_WIDTH'(8'hF0);
    assign jump = !skipped && f_op == JMP_OP;
`else
    assign jump = 1'b0;
`endif
    // HALT, JMP and skipped words all reach the execution unit as a NOP
    assign nop = skipped || halt || jump;
    assign e_op = nop ? '0 : f_op;
    assign e_opd = nop ? '0 : f_opd;
    assign last = pc == '1;
    assign skip_op = e_op == SNZA_OP || e_op == SNZS_OP;
    // ROM data only arrives in ISSUE, so the fresh word bypasses the hold register
    assign opcode = state == ISSUE ? e_op : op_r;
    assign operand = state == ISSUE ? e_opd : opd_r;
    assign issue = state == ISSUE;
    assign start = state == DONE;
    assign busy = state != IDLE;
    assign rom_en = state == FETCH;
    assign rom_addr = pc;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            skip_pend <= 1'b0;
            op_r <= '0;
            opd_r <= '0;
        end else begin
            case (state)
                IDLE: state <= run ? FETCH : IDLE;
                FETCH: state <= ISSUE;
                ISSUE: begin
                    op_r <= e_op;
                    opd_r <= e_opd;
                    skip_pend <= skip_op && !last;
                    if (jump) begin
                        pc <= f_opd[ROM_ADDRESS_WIDTH-1:0];
                        state <= FETCH;
                    end else if (halt || last) begin
                        state <= DONE;
                    end else begin
                        pc <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: begin
                    pc <= '0;
                    skip_pend <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: table-driven cycle vectors plus a full-ROM sequence.
module tb_program_sequencer;
    logic clk = 1'b0, reset = 1'b1, run = 1'b0, skip_cond = 1'b0;
    logic rom_en, issue, busy, start;
    logic [4:0] rom_addr, pc;
    logic [15:0] rom_data = '0;
    logic [7:0] opcode, operand;
    logic [15:0] rom [32];
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic rst, run, sc;
        logic iss, st, busy, en;
        logic [4:0] addr, pc;
        logic [7:0] op, opd;
    } vec_t;
    vec_t q[$];

    program_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .skip_cond(skip_cond),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .opcode(opcode), .operand(operand), .issue(issue), .busy(busy),
        .start(start), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic add(input logic r, input logic rn, input logic sc, input logic iss, input logic st,
                       input logic b, input logic en, input logic [4:0] a, input logic [4:0] p,
                       input logic [7:0] o, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.run = rn; v.sc = sc; v.iss = iss; v.st = st; v.busy = b; v.en = en;
        v.addr = a; v.pc = p; v.op = o; v.opd = d;
        q.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic play(input string name);
        for (int i = 0; i < q.size(); i++) begin
            reset = q[i].rst; run = q[i].run; skip_cond = q[i].sc;
            @(negedge clk);
            n_cmp++;
            if ({issue, start, busy, rom_en, rom_addr, pc, opcode, operand} !==
                {q[i].iss, q[i].st, q[i].busy, q[i].en, q[i].addr, q[i].pc, q[i].op, q[i].opd}) begin
                n_bad++;
                $display("FAIL %s row %0d: got iss=%b st=%b busy=%b en=%b addr=%0d pc=%0d op=%h/%h want iss=%b st=%b busy=%b en=%b addr=%0d pc=%0d op=%h/%h",
                         name, i, issue, start, busy, rom_en, rom_addr, pc, opcode, operand,
                         q[i].iss, q[i].st, q[i].busy, q[i].en, q[i].addr, q[i].pc, q[i].op, q[i].opd);
            end
            @(posedge clk); #1;
        end
        q.delete();
        reset = 1'b0; run = 1'b0; skip_cond = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0112; rom[1] = 16'h0234; rom[2] = 16'hFF00;
    endtask

    task automatic basic_rows(input logic run_busy);
        add(0,1,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        add(0,0,0, 0,0,1,1, 0,0, 8'h00,8'h00);
        add(0,0,0, 1,0,1,0, 0,0, 8'h01,8'h12);
        add(0,run_busy,0, 0,0,1,1, 1,1, 8'h01,8'h12);
        add(0,run_busy,0, 1,0,1,0, 1,1, 8'h02,8'h34);
        add(0,0,0, 0,0,1,1, 2,2, 8'h02,8'h34);
        add(0,0,0, 1,0,1,0, 2,2, 8'h00,8'h00);
        add(0,0,0, 0,1,1,0, 2,2, 8'h00,8'h00);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
    endtask

    task automatic skip_rows(input logic sc, input logic [7:0] o2, input logic [7:0] d2);
        add(0,1,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        add(0,0,0, 0,0,1,1, 0,0, 8'h00,8'h00);
        add(0,0,1, 1,0,1,0, 0,0, 8'h0A,8'h77);
        add(0,0,0, 0,0,1,1, 1,1, 8'h0A,8'h77);
        add(0,0,sc, 1,0,1,0, 1,1, o2,d2);
        add(0,0,0, 0,0,1,1, 2,2, o2,d2);
        add(0,0,0, 1,0,1,0, 2,2, 8'h00,8'h00);
        add(0,0,0, 0,1,1,0, 2,2, 8'h00,8'h00);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
    endtask

    initial begin
        int st_k, busy_k, n_iss;
        load_basic();
        repeat (2) @(posedge clk);
        #1;
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        play("reset_state");

        load_basic();
        basic_rows(1'b1);
        play("basic_run");

        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0A77; rom[1] = 16'h0555; rom[2] = 16'hFF00;
        skip_rows(1'b1, 8'h00, 8'h00);
        play("skip_taken");
        skip_rows(1'b0, 8'h05, 8'h55);
        play("skip_not_taken");

        load_basic();
        add(0,1,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        add(0,0,0, 0,0,1,1, 0,0, 8'h00,8'h00);
        add(0,0,0, 1,0,1,0, 0,0, 8'h01,8'h12);
        add(0,0,0, 0,0,1,1, 1,1, 8'h01,8'h12);
        add(0,0,0, 1,0,1,0, 1,1, 8'h02,8'h34);
        add(1,0,0, 0,0,1,1, 2,2, 8'h02,8'h34);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        play("mid_reset");
        basic_rows(1'b0);
        play("restart_after_reset");

        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0111; rom[1] = 16'h0222; rom[2] = 16'h0333; rom[3] = 16'hF001; rom[4] = 16'hFF00;
        add(0,1,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        add(0,0,0, 0,0,1,1, 0,0, 8'h00,8'h00);
        add(0,0,0, 1,0,1,0, 0,0, 8'h01,8'h11);
        add(0,0,0, 0,0,1,1, 1,1, 8'h01,8'h11);
        add(0,0,0, 1,0,1,0, 1,1, 8'h02,8'h22);
        add(0,0,0, 0,0,1,1, 2,2, 8'h02,8'h22);
        add(0,0,0, 1,0,1,0, 2,2, 8'h03,8'h33);
        add(0,0,0, 0,0,1,1, 3,3, 8'h03,8'h33);
`ifdef SEQ_JUMP_EN
        add(0,0,0, 1,0,1,0, 3,3, 8'h00,8'h00);
        add(0,0,0, 0,0,1,1, 1,1, 8'h00,8'h00);
        add(0,0,0, 1,0,1,0, 1,1, 8'h02,8'h22);
        add(1,0,0, 0,0,1,1, 2,2, 8'h02,8'h22);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
`else
        add(0,0,0, 1,0,1,0, 3,3, 8'hF0,8'h01);
        add(0,0,0, 0,0,1,1, 4,4, 8'hF0,8'h01);
        add(0,0,0, 1,0,1,0, 4,4, 8'h00,8'h00);
        add(0,0,0, 0,1,1,0, 4,4, 8'h00,8'h00);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
`endif
        play("jump_word");

        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[31] = 16'h0A00;
        run = 1'b1; skip_cond = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        st_k = 0; busy_k = 0; n_iss = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (issue) n_iss++;
            if (start && st_k == 0) st_k = k;
            if (busy) busy_k = k;
            @(posedge clk); #1;
        end
        check("full_rom_issues", n_iss, 32);
        check("full_rom_start_cycle", st_k, 65);
        check("full_rom_busy_last", busy_k, 65);
        check("full_rom_pc_after", {27'd0, pc}, 0);

        rom[0] = 16'h0123;
        add(0,1,1, 0,0,0,0, 0,0, 8'h0A,8'h00);
        add(0,0,1, 0,0,1,1, 0,0, 8'h0A,8'h00);
        add(0,0,1, 1,0,1,0, 0,0, 8'h01,8'h23);
        add(1,0,1, 0,0,1,1, 1,1, 8'h01,8'h23);
        add(0,0,0, 0,0,0,0, 0,0, 8'h00,8'h00);
        play("last_addr_skip_ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
